// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: receive end of a scanned, multiplexed 7-segment display.
// Watches the segment and anode lines and rebuilds the displayed number. A digit
// is captured once its anode+pattern pair has been stable for STABLE_CYC samples,
// decoded to BCD, collected into a scan frame, converted to binary (MSD first) and
// announced with a one-cycle valid pulse together with a sticky per-frame error.
// Optional feature: define SSEG_SCAN_BLANK_EN to accept an all-segments-off digit
// as a legal blanked zero (leading-zero suppression); otherwise it is an error.
module sseg_scan_capture #(
  parameter int NDIG        = 2,
  parameter int STABLE_CYC  = 4,
  parameter int SEG_ACT_LOW = 1,
  parameter int BIN_W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:6]        SSeg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] bcd,
  output logic [BIN_W-1:0]  num,
  output logic              valid,
  output logic              err
);

  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC + 1) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [NDIG-1:0] MASK_FULL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_HELD,
    S_CONVERT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] dig;
  } dec_t;

  // Active-high a..g with segment a in the MSB, so literals read like the table.
  function automatic dec_t decode(input logic [6:0] p);
    dec_t d;
    d.ok = 1'b1;
    case (p)
      7'b1111110: d.dig = 4'd0;
      7'b0110000: d.dig = 4'd1;
      7'b1101101: d.dig = 4'd2;
      7'b1111001: d.dig = 4'd3;
      7'b0110011: d.dig = 4'd4;
      7'b1011011: d.dig = 4'd5;
      7'b1011111: d.dig = 4'd6;
      7'b1110000: d.dig = 4'd7;
      7'b1111111: d.dig = 4'd8;
      7'b1111011: d.dig = 4'd9;
`ifdef SSEG_SCAN_BLANK_EN
      7'b0000000: d.dig = 4'd0;
`endif
      default: begin
        d.ok  = 1'b0;
        d.dig = 4'd0;
      end
    endcase
    return d;
  endfunction

  // Segment lines reordered so a lands in bit 6.
  logic [6:0] seg_raw;
  assign seg_raw = {SSeg[0], SSeg[1], SSeg[2], SSeg[3], SSeg[4], SSeg[5], SSeg[6]};

  // Normalised (active-high) registered copies of the display lines.
  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;

  // Capture state.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [NDIG-1:0]  cur_an_q;
  logic [6:0]       cur_seg_q;
  logic [NDIG-1:0]  mask_q;
  logic [3:0]       dig_q [NDIG];

  // Conversion and result registers.
  logic [IDX_W-1:0]  idx_q;
  logic [BIN_W-1:0]  acc_q;
  logic [BIN_W-1:0]  num_q;
  logic [4*NDIG-1:0] bcd_q;
  logic              valid_q;
  logic              err_q;

  // Control strobes from the FSM to the datapath.
  logic start, cnt_inc, cnt_clr, capture, conv_step, done, set_err;

  logic             one_act, multi_act, same_pair, frame_full;
  logic [IDX_W-1:0] cap_idx;
  dec_t             seg_dec;

  // Register the display lines once, converted to active-high.
  // NOTE: every clocked block uses non-blocking (<=) so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
    end else if (SEG_ACT_LOW != 0) begin
      seg_q <= ~seg_raw;
      an_q  <= ~an;
    end else begin
      seg_q <= seg_raw;
      an_q  <= an;
    end
  end

  assign one_act    = ($countones(an_q) == 1);
  assign multi_act  = ($countones(an_q) > 1);
  assign same_pair  = (an_q == cur_an_q) && (seg_q == cur_seg_q);
  assign frame_full = ((mask_q | an_q) == MASK_FULL);
  assign seg_dec    = decode(seg_q);

  // Translate the single active anode into its bcd slot index.
  // NOTE: always_comb blocks assign a default first so no latch is inferred.
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an_q[i]) cap_idx = IDX_W'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state and datapath strobes.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    capture   = 1'b0;
    conv_step = 1'b0;
    done      = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      S_IDLE, S_SETTLE, S_HELD: begin
        if (state_q != S_IDLE && same_pair) begin
          // Pair unchanged: keep counting while settling, otherwise just hold.
          if (state_q == S_SETTLE) begin
            if (cnt_q >= CNT_W'(STABLE_CYC - 1)) capture = 1'b1;
            else                                 cnt_inc = 1'b1;
          end
        end else if (multi_act) begin
          set_err = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_IDLE;
        end else if (one_act) begin
          start = 1'b1;
          if (STABLE_CYC <= 1) capture = 1'b1;
          else                 state_d = S_SETTLE;
        end else begin
          cnt_clr = 1'b1;
          state_d = S_IDLE;
        end
        if (capture) begin
          state_d = frame_full ? S_CONVERT : S_HELD;
          if (!seg_dec.ok) set_err = 1'b1;
        end
      end
      S_CONVERT: begin
        conv_step = 1'b1;
        if (idx_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stability counter and the anode+pattern pair being watched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      cur_an_q  <= '0;
      cur_seg_q <= '0;
    end else begin
      if (start)        cnt_q <= CNT_W'(1);
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      else if (cnt_clr) cnt_q <= '0;
      if (start) begin
        cur_an_q  <= an_q;
        cur_seg_q <= seg_q;
      end
    end
  end

  // Digit store and frame mask; a completed frame clears the mask for the next one.
  // NOTE: the digit store is small, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= 4'd0;
    end else if (capture) begin
      dig_q[cap_idx] <= seg_dec.dig;
      mask_q         <= frame_full ? '0 : (mask_q | an_q);
    end
  end

  // BCD to binary, most significant digit first: acc = acc*10 + digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (capture && frame_full) begin
      idx_q <= IDX_W'(NDIG - 1);
      acc_q <= '0;
    end else if (conv_step) begin
      acc_q <= acc_q * BIN_W'(10) + BIN_W'(dig_q[idx_q]);
      idx_q <= idx_q - IDX_W'(1);
    end
  end

  // Publish a finished frame; err is sticky until the cycle after the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= done;
      if (done) begin
        num_q <= acc_q;
        for (int i = 0; i < NDIG; i++) bcd_q[4*i +: 4] <= dig_q[i];
      end
      if (set_err)      err_q <= 1'b1;
      else if (valid_q) err_q <= 1'b0;
    end
  end

  assign bcd   = bcd_q;
  assign num   = num_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// tb_sseg_scan_capture: directed scans plus randomized frames for sseg_scan_capture,
// driven as an active-low common-anode display and checked against a digit-level model.
module tb_sseg_scan_capture;

  localparam int NDIG       = 2;
  localparam int STABLE_CYC = 4;
  localparam int BIN_W      = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:6]        SSeg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] bcd;
  logic [BIN_W-1:0]  num;
  logic              valid;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  sseg_scan_capture #(
    .NDIG(NDIG), .STABLE_CYC(STABLE_CYC), .SEG_ACT_LOW(1), .BIN_W(BIN_W)
  ) dut (
    .clk(clk), .rst(rst), .SSeg(SSeg), .an(an),
    .bcd(bcd), .num(num), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  // Active-high a..g patterns, segment a in the MSB.
  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  typedef struct {
    int num;
    int bcd;
    int err;
    int cyc;
  } frame_t;

  frame_t obs_q[$];
  frame_t exp_q[$];
  int     cyc_cnt   = 0;
  int     wide_cnt  = 0;
  logic   prev_valid = 1'b0;
  logic   err_after;

  logic [6:0] pats  [NDIG];
  int         dwell [NDIG];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Record every valid pulse, its cycle, its width and the err value just after it.
  always begin
    @(posedge clk);
    cyc_cnt++;
    #1;
    if (valid) begin
      frame_t f;
      f.num = int'(num);
      f.bcd = int'(bcd);
      f.err = int'(err);
      f.cyc = cyc_cnt;
      obs_q.push_back(f);
    end
    if (valid && prev_valid) wide_cnt++;
    if (prev_valid) err_after = err;
    prev_valid = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one digit position (active-high anode mask and pattern) for some cycles.
  task automatic show(input logic [NDIG-1:0] an_ah, input logic [6:0] pat, input int cycles);
    an   = ~an_ah;
    SSeg = ~pat;
    repeat (cycles) tick();
  endtask

  task automatic idle(input int cycles);
    show('0, 7'b0, cycles);
  endtask

  function automatic bit in_table(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (SEG_TBL[d] == p) return 1'b1;
    return 1'b0;
  endfunction

  // Reference decode: a table lookup, with the optional blank digit.
  function automatic bit decode_ref(input logic [6:0] p, output int v);
    v = 0;
    for (int d = 0; d < 10; d++) begin
      if (SEG_TBL[d] == p) begin
        v = d;
        return 1'b1;
      end
    end
`ifdef SSEG_SCAN_BLANK_EN
    if (p == 7'b0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Expected frame result from the displayed patterns (index 0 = units).
  function automatic frame_t model_frame();
    frame_t f;
    int v;
    int scale = 1;
    f.num = 0; f.bcd = 0; f.err = 0; f.cyc = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (!decode_ref(pats[i], v)) f.err = 1;
      f.num += v * scale;
      f.bcd |= v << (4 * i);
      scale *= 10;
    end
    return f;
  endfunction

  function automatic logic [6:0] bad_pattern();
    logic [6:0] p;
    do p = 7'($urandom_range(0, 127)); while (in_table(p));
    return p;
  endfunction

  task automatic set_num(input int value);
    int v = value;
    for (int i = 0; i < NDIG; i++) begin
      pats[i]  = SEG_TBL[v % 10];
      dwell[i] = 8;
      v = v / 10;
    end
  endtask

  // Scan the current pats/dwell once, MSD first, and log the expected frame.
  task automatic scan();
    exp_q.push_back(model_frame());
    for (int i = NDIG - 1; i >= 0; i--) show(NDIG'(1 << i), pats[i], dwell[i]);
  endtask

  task automatic expect_frames(input string tag);
    check({tag, " pulses"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d] num", tag, i), obs_q[i].num, exp_q[i].num);
      check($sformatf("%s[%0d] bcd", tag, i), obs_q[i].bcd, exp_q[i].bcd);
      check($sformatf("%s[%0d] err", tag, i), obs_q[i].err, exp_q[i].err);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int     t0;
    frame_t e;

    // Reset held with random inputs: outputs stay cleared.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      an   = NDIG'($urandom);
      SSeg = 7'($urandom);
      tick();
      check($sformatf("reset c%0d bcd", c),   32'(bcd),   32'd0);
      check($sformatf("reset c%0d num", c),   32'(num),   32'd0);
      check($sformatf("reset c%0d valid", c), 32'(valid), 32'd0);
      check($sformatf("reset c%0d err", c),   32'(err),   32'd0);
    end
    idle(1);
    rst = 1'b0;
    idle(4);
    check("post reset pulses", obs_q.size(), 0);

    // 42: one pulse, latency = input register + STABLE_CYC samples + NDIG + 1.
    set_num(42);
    exp_q.push_back(model_frame());
    show(NDIG'(2), pats[1], 8);
    t0 = cyc_cnt;
    show(NDIG'(1), pats[0], 8);
    idle(10);
    check("t42 latency", (obs_q.size() > 0) ? obs_q[0].cyc - t0 : -1, 1 + STABLE_CYC + NDIG + 1);
    expect_frames("t42");
    check("t42 hold num", 32'(num), 32'd42);
    check("t42 hold bcd", 32'(bcd), 32'h42);

    // 59 then 17 back to back.
    set_num(59); scan();
    set_num(17); scan();
    idle(10);
    expect_frames("t59_17");

    // Short units glitch must not be captured.
    show(NDIG'(1), SEG_TBL[8], 2);
    set_num(35); scan();
    idle(10);
    expect_frames("tglitch");

    // Two anodes active mid-scan: err on the frame, cleared right after the pulse.
    err_after = 1'bx;
    show(NDIG'(2), SEG_TBL[1], 8);
    show(NDIG'(3), SEG_TBL[2], 8);
    show(NDIG'(2), SEG_TBL[1], 8);
    show(NDIG'(1), SEG_TBL[2], 8);
    idle(10);
    e.num = 12; e.bcd = 'h12; e.err = 1; e.cyc = 0;
    exp_q.push_back(e);
    expect_frames("tmulti");
    check("tmulti err cleared", 32'(err_after), 32'd0);

    // Blank tens digit, units 7.
    err_after = 1'bx;
    pats[1] = 7'b0;       dwell[1] = 8;
    pats[0] = SEG_TBL[7]; dwell[0] = 8;
    scan();
    idle(10);
    expect_frames("tblank");
    check("tblank err after", 32'(err_after), 32'd0);

    // Reset during conversion aborts the frame: no pulse, outputs cleared.
    show(NDIG'(2), SEG_TBL[8], 8);
    show(NDIG'(1), SEG_TBL[6], 6);
    rst = 1'b1;
    idle(2);
    check("abort valid", 32'(valid), 32'd0);
    check("abort num",   32'(num),   32'd0);
    check("abort bcd",   32'(bcd),   32'd0);
    rst = 1'b0;
    idle(10);
    check("abort pulses", obs_q.size(), 0);
    obs_q.delete();

    // Randomized frames with occasional invalid digits and varying dwell.
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < NDIG; i++) begin
        if ($urandom_range(0, 7) == 0) pats[i] = bad_pattern();
        else                           pats[i] = SEG_TBL[$urandom_range(0, 9)];
        dwell[i] = $urandom_range(6, 10);
      end
      scan();
    end
    idle(12);
    expect_frames("random");

    check("valid width", wide_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
